// File: rtl/fp_addsub_sign_stage.sv
// fp_addsub_sign_stage: registered sign-resolution stage for FP add/sub.
// Compares operand magnitudes and produces the result sign, swap flag,
// effective-subtract flag, absolute exponent difference and signed-zero flag.
// valid/ready handshake on both sides, single register slice.
// Optional macro FP_SIGN_SPECIAL_EN adds Inf/NaN classification outputs
// (special_res, invalid_op) and the matching sign overrides.
module fp_addsub_sign_stage #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              A_signbit,
    input  logic [EXP_W-1:0]  A_exp,
    input  logic [FRAC_W-1:0] A_frac,
    input  logic              B_signbit,
    input  logic [EXP_W-1:0]  B_exp,
    input  logic [FRAC_W-1:0] B_frac,
    input  logic              Mode,
    input  logic [2:0]        rm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              Sign,
    output logic              swap,
    output logic              eff_sub,
    output logic [EXP_W-1:0]  exp_diff,
`ifdef FP_SIGN_SPECIAL_EN
    output logic              special_res,
    output logic              invalid_op,
`endif
    output logic              zero_res
);

    localparam logic [2:0] RM_RDN = 3'b010;

    logic             sign_b;
    logic             exp_ab;
    logic             same_exp;
    logic             frac_ab;
    logic             same_mag;
    logic             big_b;
    logic             eff;
    logic             zero_n;
    logic             sign_n;
    logic [EXP_W-1:0] exp_diff_n;
    logic             accept;

`ifdef FP_SIGN_SPECIAL_EN
    logic a_nan_inf;
    logic b_nan_inf;
    logic a_inf;
    logic b_inf;
    logic a_snan;
    logic b_snan;
    logic special_n;
    logic invalid_n;
`endif

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;

    // Magnitude compare and sign resolution of the presented operand set
    always_comb begin
        sign_b     = B_signbit ^ Mode;
        exp_ab     = (B_exp > A_exp);
        same_exp   = (A_exp == B_exp);
        frac_ab    = (B_frac > A_frac);
        same_mag   = same_exp & (A_frac == B_frac);
        big_b      = exp_ab | (same_exp & frac_ab);
        eff        = A_signbit ^ sign_b;
        zero_n     = same_mag & eff;
        // larger exponent is always the minuend, so no wrap
        exp_diff_n = big_b ? (B_exp - A_exp) : (A_exp - B_exp);
        if (zero_n)
            sign_n = (rm == RM_RDN);
        else if (big_b)
            sign_n = sign_b;
        else
            sign_n = A_signbit;

`ifdef FP_SIGN_SPECIAL_EN
        a_nan_inf = &A_exp;
        b_nan_inf = &B_exp;
        a_inf     = a_nan_inf & (A_frac == '0);
        b_inf     = b_nan_inf & (B_frac == '0);
        // signalling NaN: quiet bit clear with a nonzero payload
        a_snan    = a_nan_inf & ~A_frac[FRAC_W-1] & (A_frac != '0);
        b_snan    = b_nan_inf & ~B_frac[FRAC_W-1] & (B_frac != '0);
        special_n = a_nan_inf | b_nan_inf;
        invalid_n = (a_inf & b_inf & eff) | a_snan | b_snan;
        if (invalid_n)
            sign_n = 1'b0;            // canonical NaN is positive
        else if (a_inf ^ b_inf)
            sign_n = a_inf ? A_signbit : sign_b;
`endif
    end

    // Result register slice: reset > flush > accept > handoff
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            Sign        <= 1'b0;
            swap        <= 1'b0;
            eff_sub     <= 1'b0;
            exp_diff    <= '0;
            zero_res    <= 1'b0;
`ifdef FP_SIGN_SPECIAL_EN
            special_res <= 1'b0;
            invalid_op  <= 1'b0;
`endif
        end else if (flush) begin
            // data registers keep stale values; don't-care while invalid
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            Sign        <= sign_n;
            swap        <= big_b;
            eff_sub     <= eff;
            exp_diff    <= exp_diff_n;
            zero_res    <= zero_n;
`ifdef FP_SIGN_SPECIAL_EN
            special_res <= special_n;
            invalid_op  <= invalid_n;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fp_addsub_sign_stage.sv
// Directed, table-driven bench for fp_addsub_sign_stage (FP32 geometry).
module tb_fp_addsub_sign_stage;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;

    typedef struct {
        logic              a_s;
        logic [EXP_W-1:0]  a_e;
        logic [FRAC_W-1:0] a_f;
        logic              b_s;
        logic [EXP_W-1:0]  b_e;
        logic [FRAC_W-1:0] b_f;
        logic              mode;
        logic [2:0]        rm;
        logic              x_sign;
        logic              x_swap;
        logic              x_eff;
        logic [EXP_W-1:0]  x_diff;
        logic              x_zero;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic              A_signbit;
    logic [EXP_W-1:0]  A_exp;
    logic [FRAC_W-1:0] A_frac;
    logic              B_signbit;
    logic [EXP_W-1:0]  B_exp;
    logic [FRAC_W-1:0] B_frac;
    logic              Mode;
    logic [2:0]        rm;
    logic              out_valid;
    logic              out_ready;
    logic              Sign;
    logic              swap;
    logic              eff_sub;
    logic [EXP_W-1:0]  exp_diff;
    logic              zero_res;
`ifdef FP_SIGN_SPECIAL_EN
    logic              special_res;
    logic              invalid_op;
`endif

    int n_pass  = 0;
    int n_total = 0;

    vec_t vecs[10];

    fp_addsub_sign_stage #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A_signbit (A_signbit),
        .A_exp     (A_exp),
        .A_frac    (A_frac),
        .B_signbit (B_signbit),
        .B_exp     (B_exp),
        .B_frac    (B_frac),
        .Mode      (Mode),
        .rm        (rm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sign      (Sign),
        .swap      (swap),
        .eff_sub   (eff_sub),
        .exp_diff  (exp_diff),
`ifdef FP_SIGN_SPECIAL_EN
        .special_res (special_res),
        .invalid_op  (invalid_op),
`endif
        .zero_res  (zero_res)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input vec_t v);
        A_signbit = v.a_s;
        A_exp     = v.a_e;
        A_frac    = v.a_f;
        B_signbit = v.b_s;
        B_exp     = v.b_e;
        B_frac    = v.b_f;
        Mode      = v.mode;
        rm        = v.rm;
    endtask

    task automatic check_out(input string tag, input vec_t v);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        check({tag, ".Sign"},      32'(Sign),      32'(v.x_sign));
        check({tag, ".swap"},      32'(swap),      32'(v.x_swap));
        check({tag, ".eff_sub"},   32'(eff_sub),   32'(v.x_eff));
        check({tag, ".exp_diff"},  32'(exp_diff),  32'(v.x_diff));
        check({tag, ".zero_res"},  32'(zero_res),  32'(v.x_zero));
    endtask

    initial begin
        // a_s a_e a_f  b_s b_e b_f  mode rm | sign swap eff diff zero
        vecs[0] = '{1'b0, 8'd127, 23'h400000, 1'b1, 8'd128, 23'h0,      1'b0, 3'b000, 1'b1, 1'b1, 1'b1, 8'd1,   1'b0};
        vecs[1] = '{1'b0, 8'd128, 23'h400000, 1'b0, 8'd128, 23'h400000, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 8'd0,   1'b1};
        vecs[2] = '{1'b0, 8'd128, 23'h400000, 1'b0, 8'd128, 23'h400000, 1'b1, 3'b010, 1'b1, 1'b0, 1'b1, 8'd0,   1'b1};
        vecs[3] = '{1'b1, 8'd130, 23'h000010, 1'b0, 8'd130, 23'h000020, 1'b1, 3'b000, 1'b1, 1'b1, 1'b0, 8'd0,   1'b0};
        vecs[4] = '{1'b0, 8'd200, 23'h5,      1'b0, 8'd3,   23'h7,      1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 8'd197, 1'b0};
        vecs[5] = '{1'b1, 8'd10,  23'h0,      1'b1, 8'd250, 23'h7FFFFF, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 8'd240, 1'b0};
        vecs[6] = '{1'b1, 8'd100, 23'h123,    1'b0, 8'd100, 23'h123,    1'b1, 3'b010, 1'b1, 1'b0, 1'b0, 8'd0,   1'b0};
        vecs[7] = '{1'b1, 8'd50,  23'h9,      1'b0, 8'd50,  23'h9,      1'b0, 3'b001, 1'b0, 1'b0, 1'b1, 8'd0,   1'b1};
        vecs[8] = '{1'b0, 8'd255, 23'h0,      1'b0, 8'd0,   23'h0,      1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 8'd255, 1'b0};
        vecs[9] = '{1'b1, 8'd5,   23'h400001, 1'b1, 8'd5,   23'h400000, 1'b1, 3'b011, 1'b1, 1'b0, 1'b1, 8'd0,   1'b0};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        drive(vecs[0]);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;

        // idle after reset
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst.out_valid", 32'(out_valid), 32'd0);
            check("rst.in_ready",  32'(in_ready),  32'd1);
            check("rst.fields",    {Sign, swap, eff_sub, zero_res, exp_diff}, 32'd0);
        end

        // table: back-to-back accepts with out_ready high
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            in_valid = 1'b1;
            @(posedge clk); #1;
            check_out($sformatf("vec%0d", i), vecs[i]);
        end
        @(negedge clk) in_valid = 1'b0;
        @(posedge clk); #1;
        check("drain.out_valid", 32'(out_valid), 32'd0);

        // backpressure: vec0 held while new operands wait
        @(negedge clk); drive(vecs[0]); in_valid = 1'b1;
        @(posedge clk); #1;
        check_out("bp.first", vecs[0]);
        @(negedge clk); out_ready = 1'b0; drive(vecs[4]);
        for (int i = 0; i < 4; i++) begin
            #1 check("bp.in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            check_out($sformatf("bp.hold%0d", i), vecs[0]);
            @(negedge clk);
            drive(i == 1 ? vecs[5] : vecs[4]);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_out("bp.next", vecs[4]);
        @(negedge clk) drive(vecs[5]);
        @(posedge clk); #1;
        check_out("bp.b2b", vecs[5]);
        @(negedge clk) in_valid = 1'b0;
        @(posedge clk); #1;
        check("bp.drain", 32'(out_valid), 32'd0);

        // flush with a same-cycle accept
        @(negedge clk); drive(vecs[3]); in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        check("flush.accept_dropped", 32'(out_valid), 32'd0);
        @(negedge clk); flush = 1'b0; drive(vecs[1]);
        @(posedge clk); #1;
        check_out("flush.after", vecs[1]);
        // flush of a stalled held result
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        check("flush.held_dropped", 32'(out_valid), 32'd0);
        @(negedge clk); flush = 1'b0; out_ready = 1'b1;

`ifdef FP_SIGN_SPECIAL_EN
        // +Inf - +Inf: invalid
        @(negedge clk);
        A_signbit = 1'b0; A_exp = 8'hFF; A_frac = '0;
        B_signbit = 1'b0; B_exp = 8'hFF; B_frac = '0;
        Mode = 1'b1; rm = 3'b010; in_valid = 1'b1;
        @(posedge clk); #1;
        check("sp.inf_inf.invalid", 32'(invalid_op),  32'd1);
        check("sp.inf_inf.special", 32'(special_res), 32'd1);
        check("sp.inf_inf.Sign",    32'(Sign),        32'd0);
        // +Inf + 1.0
        @(negedge clk);
        B_exp = 8'd127; Mode = 1'b0; rm = 3'b000;
        @(posedge clk); #1;
        check("sp.inf_one.invalid", 32'(invalid_op),  32'd0);
        check("sp.inf_one.special", 32'(special_res), 32'd1);
        check("sp.inf_one.Sign",    32'(Sign),        32'd0);
        // 1.0 - (+Inf): sign follows B's effective sign
        @(negedge clk);
        A_exp = 8'd127; B_exp = 8'hFF; Mode = 1'b1;
        @(posedge clk); #1;
        check("sp.one_minf.Sign",   32'(Sign),        32'd1);
        // sNaN operand
        @(negedge clk);
        A_exp = 8'd10; B_exp = 8'hFF; B_frac = 23'h1; Mode = 1'b0;
        @(posedge clk); #1;
        check("sp.snan.invalid",    32'(invalid_op),  32'd1);
        @(negedge clk) in_valid = 1'b0;
`endif

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fp_addsub_sign_stage.md
Name: fp_addsub_sign_stage

Overview:
- Registered, parametrised sign-resolution stage for the floating-point add/sub datapath.
- Per operation, it:
  - compares operand magnitudes;
  - produces the result sign, operand swap flag, effective-subtract flag and absolute exponent difference;
  - applies IEEE-754 signed-zero rules for exact cancellation, based on the rounding mode.
- Sits between operand unpack and the alignment shifter, with a valid/ready handshake on both sides.

Parameters:
- EXP_W, 8, exponent field width (8 = FP32, 11 = FP64)
- FRAC_W, 23, fraction field width, without the hidden bit

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high reset
- flush  input  1  synchronous pipeline kill; drops the held result
- in_valid  input  1  operand set valid
- in_ready  output  1  stage can accept an operand set this cycle
- A_signbit  input  1  sign of A
- A_exp  input  EXP_W  biased exponent of A
- A_frac  input  FRAC_W  fraction of A
- B_signbit  input  1  sign of B
- B_exp  input  EXP_W  biased exponent of B
- B_frac  input  FRAC_W  fraction of B
- Mode  input  1  0 = A+B, 1 = A−B
- rm  input  3  rounding mode (RISC-V encoding; 3'b010 = RDN)
- out_valid  output  1  registered result valid
- out_ready  input  1  downstream accepts the result
- Sign  output  1  result sign, 1 = negative
- swap  output  1  1 = |B| > |A|; downstream treats B as the larger operand
- eff_sub  output  1  effective subtraction (magnitudes subtract)
- exp_diff  output  EXP_W  |A_exp − B_exp|, unsigned
- zero_res  output  1  exact cancellation; result is a signed zero

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - The reset branch has priority over everything.
  - On reset: out_valid=0, Sign=0, swap=0, eff_sub=0, exp_diff=0, zero_res=0.
- Combinational decode of the input set:
  - sign_B = B_signbit ^ Mode.
  - exp_AB = (B_exp > A_exp).
  - same_exp = (A_exp == B_exp).
  - frac_AB = (B_frac > A_frac).
  - same_mag = same_exp & (A_frac == B_frac).
  - big_B = exp_AB | (same_exp & frac_AB).
  - eff = A_signbit ^ sign_B.
- Next-state values:
  - swap_n = big_B.
  - eff_sub_n = eff.
  - exp_diff_n = big_B ? B_exp − A_exp : A_exp − B_exp. The result is EXP_W bits wide and never wraps, because the larger operand is always the minuend.
  - zero_n = same_mag & eff.
  - Sign_n:
    - if zero_n: (rm == 3'b010) ? 1 : 0;
    - else if big_B: sign_B;
    - else: A_signbit.
  - Equal magnitudes with the same effective sign give Sign_n = A_signbit and zero_n = 0.
- Handshake:
  - in_ready = ~out_valid | out_ready. This is combinational, with no dependency on in_valid.
  - An operand set is accepted when in_valid & in_ready. On acceptance all result registers load the _n values and out_valid is set to 1 on the next edge.
  - Result handoff occurs when out_valid & out_ready:
    - with no simultaneous accept, out_valid is set to 0;
    - with a simultaneous accept, the new result loads back-to-back.
  - Throughput is 1 result per cycle when out_ready is held high.
  - Latency is 1 cycle, from accept edge to out_valid.
- Stall: while out_valid & ~out_ready, all result outputs hold stable and in_ready=0.
- flush:
  - Asserted in a cycle, it forces out_valid=0 on the next edge.
  - Any same-cycle accept is discarded; flush wins over in_valid.
  - Data registers may keep stale values and are don't-care while out_valid=0.
- Data registers load only on accept. No X may propagate to outputs after reset.
- Inputs are sampled only on accept, so input changes during a stall are ignored.

Optional Feature:
- Macro: FP_SIGN_SPECIAL_EN. When defined, the following are added:
  - Extra output: special_res (1 bit).
  - Extra output: invalid_op (1 bit).
  - Special classification of the input set:
    - An operand is Inf or NaN when its exp is all-ones.
    - special_res = 1 when either operand is Inf or NaN.
    - invalid_op = 1 when both operands are Inf (frac == 0) and eff = 1, or when either operand is a signalling NaN (frac MSB == 0 and frac != 0).
  - Sign on special cases:
    - If exactly one operand is Inf, Sign takes that operand's effective sign.
    - For an invalid operation, Sign = 0 (canonical NaN).
  - Both new outputs register with the same accept/stall/flush rules and reset to 0.
- When the macro is undefined:
  - Neither port exists.
  - All-ones exponents are treated as ordinary magnitudes.

Test Plan:
- Reset, then in_valid=0 for 3 cycles -> out_valid=0, all outputs 0, in_ready=1.
- FP32: A=1.5 (0,127,0x400000), B=−2.0 (1,128,0), Mode=0, out_ready=1 -> one cycle later: out_valid=1, Sign=1, swap=1, exp_diff=1, eff_sub=1, zero_res=0.
- A=3.0 (0,128,0x400000), B=3.0, Mode=1:
  - rm=3'b000 -> zero_res=1, Sign=0;
  - repeat with rm=3'b010 -> Sign=1.
- A=(1,130,0x000010), B=(0,130,0x000020), Mode=1 -> Sign=1, swap=1, eff_sub=0, exp_diff=0.
- Backpressure:
  - Hold out_ready=0 for 4 cycles after one result while in_valid=1 with new operands. in_ready must be 0 and outputs stable.
  - Then set out_ready=1 -> the next set appears one cycle later, back-to-back at 1/cycle.
- flush asserted in the same cycle as an accept -> out_valid=0 next cycle. A later accept proceeds normally.
- With FP_SIGN_SPECIAL_EN:
  - A=+Inf (0,255,0), B=+Inf, Mode=1 -> invalid_op=1, special_res=1, Sign=0.
  - A=+Inf, B=+1.0 (0,127,0), Mode=0 -> invalid_op=0, special_res=1, Sign=0.
